// File: rtl/fp_acc_stream.sv
// Sequential FP32 accumulator: sums N_TERMS products through an align/add/normalise
// datapath (one term per 4 clocks), emits the sum as a one-cycle pulse, then self-clears.
module fp_acc_stream #(
  parameter int unsigned N_TERMS = 784
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [31:0] in_data,
  output logic        in_rdy,
  output logic        out_vld,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam int unsigned MAN_W = 25;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_NORM  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [31:0]      acc, op_a, op_b;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [MAN_W-1:0] big_m_q, sml_m_q, mag_q;
  logic [7:0]       big_e_q, mag_e_q;
  logic             big_s_q, sub_q, mag_s_q;
  logic             spc_q, spc2_q;
  logic [31:0]      spc_val_q, spc2_val_q;

  assign in_rdy = (state == S_IDLE) && !clr;
  assign accept = in_vld && in_rdy;
  assign busy   = (state != S_IDLE) || (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_ALIGN;
        S_ALIGN: state_nxt = S_ADD;
        S_ADD:   state_nxt = S_NORM;
        S_NORM:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ALIGN: flush denormals, order by magnitude, align the smaller mantissa, resolve specials
  logic [7:0]       a_e, b_e, big_e, sml_e, shift_amt;
  logic [22:0]      a_m, b_m, big_m, sml_m;
  logic             a_nan, b_nan, a_inf, b_inf, big_s, sml_s;
  logic [MAN_W-1:0] sml_full, sml_aligned;
  logic             spc_nxt;
  logic [31:0]      spc_val_nxt;

  always_comb begin
    a_e   = op_a[30:23];
    b_e   = op_b[30:23];
    a_m   = (a_e == 8'h00) ? 23'h0 : op_a[22:0];
    b_m   = (b_e == 8'h00) ? 23'h0 : op_b[22:0];
    a_nan = (a_e == 8'hFF) && (a_m != 23'h0);
    b_nan = (b_e == 8'hFF) && (b_m != 23'h0);
    a_inf = (a_e == 8'hFF) && (a_m == 23'h0);
    b_inf = (b_e == 8'hFF) && (b_m == 23'h0);
    if ({a_e, a_m} >= {b_e, b_m}) begin
      big_e = a_e; big_m = a_m; big_s = op_a[31];
      sml_e = b_e; sml_m = b_m; sml_s = op_b[31];
    end else begin
      big_e = b_e; big_m = b_m; big_s = op_b[31];
      sml_e = a_e; sml_m = a_m; sml_s = op_a[31];
    end
    shift_amt   = big_e - sml_e;
    sml_full    = {1'b0, sml_e != 8'h00, sml_m};
    sml_aligned = (shift_amt >= 8'd25) ? '0 : (sml_full >> shift_amt);
    spc_nxt     = 1'b0;
    spc_val_nxt = 32'h0;
    if (a_nan || b_nan || (a_inf && b_inf && (op_a[31] != op_b[31]))) begin
      spc_nxt     = 1'b1;
      spc_val_nxt = 32'h7FFF_FFFF;
    end else if (a_inf) begin
      spc_nxt     = 1'b1;
      spc_val_nxt = {op_a[31], 8'hFF, 23'h0};
    end else if (b_inf) begin
      spc_nxt     = 1'b1;
      spc_val_nxt = {op_b[31], 8'hFF, 23'h0};
    end
  end

  // NORM: carry shift or leading-zero shift, then overflow/underflow clamps
  logic [4:0]        lz;
  logic signed [9:0] exp_adj;
  logic [22:0]       norm_man;
  logic [31:0]       res;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (mag_q[i]) lz = 5'(23 - i);
    end
    exp_adj  = 10'sd0;
    norm_man = 23'h0;
    res      = 32'h0;
    if (spc2_q) begin
      res = spc2_val_q;
    end else if (mag_q != '0) begin
      if (mag_q[MAN_W-1]) begin
        exp_adj  = $signed({2'b00, mag_e_q}) + 10'sd1;
        norm_man = 23'(mag_q >> 1);
      end else begin
        exp_adj  = $signed({2'b00, mag_e_q}) - $signed({5'b00000, lz});
        norm_man = 23'(mag_q << lz);
      end
      if (exp_adj >= 10'sd255)   res = {mag_s_q, 8'hFF, 23'h0};
      else if (exp_adj <= 10'sd0) res = 32'h0;
      else                        res = {mag_s_q, exp_adj[7:0], norm_man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 32'h0;
      cnt        <= '0;
      op_a       <= 32'h0;
      op_b       <= 32'h0;
      out_vld    <= 1'b0;
      out_data   <= 32'h0;
      big_m_q    <= '0;
      sml_m_q    <= '0;
      big_e_q    <= 8'h0;
      big_s_q    <= 1'b0;
      sub_q      <= 1'b0;
      spc_q      <= 1'b0;
      spc_val_q  <= 32'h0;
      mag_q      <= '0;
      mag_e_q    <= 8'h0;
      mag_s_q    <= 1'b0;
      spc2_q     <= 1'b0;
      spc2_val_q <= 32'h0;
    end else if (clr) begin
      acc     <= 32'h0;
      cnt     <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a <= acc;
            op_b <= in_data;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          big_m_q   <= {1'b0, big_e != 8'h00, big_m};
          sml_m_q   <= sml_aligned;
          big_e_q   <= big_e;
          big_s_q   <= big_s;
          sub_q     <= big_s != sml_s;
          spc_q     <= spc_nxt;
          spc_val_q <= spc_val_nxt;
        end
        S_ADD: begin
          mag_q      <= sub_q ? (big_m_q - sml_m_q) : (big_m_q + sml_m_q);
          mag_e_q    <= big_e_q;
          mag_s_q    <= big_s_q;
          spc2_q     <= spc_q;
          spc2_val_q <= spc_val_q;
        end
        default: begin
          if (cnt == CNT_W'(N_TERMS)) begin
            out_data <= res;
            out_vld  <= 1'b1;
            acc      <= 32'h0;
            cnt      <= '0;
          end else begin
            acc <= res;
          end
        end
      endcase
    end
  end

endmodule
